// File: rtl/forward_sel_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : forward_sel_unit_pkg
// Description : Shared definitions for the forwarding-select unit. Holds the
//               operand-mux select encoding, the shadow-stage record, and
//               the priority helper that turns stage hits into a select code.
// Revision    : 1.0 - initial release
// ============================================================================
package forward_sel_unit_pkg;

  // Widest register address the shadow record can hold. Narrower address
  // buses are zero-extended into this field, which keeps the record type
  // independent of the top-level REG_ADDR_W parameter.
  localparam int MAX_REG_ADDR_W = 16;

  // Operand-mux select encoding seen by the EX-stage 3-input muxes.
  // 2'b11 is never produced.
  localparam logic [1:0] FWD_RF    = 2'b00;  // register-file read value
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB writeback data

  // One shadow pipeline stage: the destination register and what kind of
  // write the instruction in that stage will perform.
  typedef struct packed {
    logic [MAX_REG_ADDR_W-1:0] rd;
    logic                      wr_en;
    logic                      is_load;
  } shadow_stage_t;

  // An empty slot: no write, no load.
  localparam shadow_stage_t SHADOW_BUBBLE = '{rd: '0, wr_en: 1'b0, is_load: 1'b0};

  // Map the two producer hits to a select code. The newer producer (the one
  // one stage ahead of the consumer) always wins.
  function automatic logic [1:0] fwd_select(input logic hit_newer, input logic hit_older);
    logic [1:0] sel;
    sel = FWD_RF;
    if (hit_newer) begin
      sel = FWD_EXMEM;
    end else if (hit_older) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage : forward_sel_unit_pkg
`default_nettype wire

// File: rtl/forward_sel_unit_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : fwd_match
// Description : Combinational dependency comparator. Reports whether a
//               consumer's source register is written by a producer stage.
//               Register 0 never matches, so it is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_match #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] src_addr_i,   // consumer source register
  input  logic              src_used_i,   // consumer actually reads it
  input  logic [ADDR_W-1:0] dst_addr_i,   // producer destination register
  input  logic              dst_wr_en_i,  // producer writes its destination
  output logic              match_o
);

  logic w_addr_eq;
  logic w_addr_nonzero;

  assign w_addr_eq      = (src_addr_i == dst_addr_i);
  assign w_addr_nonzero = (src_addr_i != '0);

  assign match_o = src_used_i & dst_wr_en_i & w_addr_eq & w_addr_nonzero;

endmodule : fwd_match
`default_nettype wire

// File: rtl/forward_sel_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_sel_unit
// Description : Forwarding-select and load-use hazard unit for a 5-stage
//               pipeline. Tracks destination registers of the instructions
//               in ID/EX, EX/MEM and MEM/WB in shadow stages, produces
//               registered operand-mux selects for the instruction entering
//               EX, raises a combinational stall on a load-use dependency and
//               counts stall cycles with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_sel_unit
  import forward_sel_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  ex_flush,
  output logic [1:0]            ex_sel_a,
  output logic [1:0]            ex_sel_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  shadow_stage_t    idex_q,  idex_d;
  shadow_stage_t    exmem_q;
  shadow_stage_t    memwb_q;
  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // --------------------------------------------------------------------------
  // ID-stage addresses widened to the shadow-record width
  // --------------------------------------------------------------------------
  logic [MAX_REG_ADDR_W-1:0] w_id_rs;
  logic [MAX_REG_ADDR_W-1:0] w_id_rt;
  logic [MAX_REG_ADDR_W-1:0] w_id_rd;

  // Zero-extend the ID addresses so they compare directly against shadow rd.
  always_comb begin
    w_id_rs = '0;
    w_id_rt = '0;
    w_id_rd = '0;
    w_id_rs[REG_ADDR_W-1:0] = id_rs;
    w_id_rt[REG_ADDR_W-1:0] = id_rt;
    w_id_rd[REG_ADDR_W-1:0] = id_rd;
  end

  // --------------------------------------------------------------------------
  // Dependency comparators. Compared now against ID/EX and EX/MEM, these are
  // the producers that will sit in EX/MEM and MEM/WB respectively once the
  // ID instruction has moved into EX.
  // --------------------------------------------------------------------------
  logic w_rs_hit_idex;
  logic w_rt_hit_idex;
  logic w_rs_hit_exmem;
  logic w_rt_hit_exmem;

  fwd_match #(.ADDR_W(MAX_REG_ADDR_W)) u_match_rs_exmem (
    .src_addr_i  (w_id_rs),
    .src_used_i  (id_use_rs),
    .dst_addr_i  (idex_q.rd),
    .dst_wr_en_i (idex_q.wr_en),
    .match_o     (w_rs_hit_idex)
  );

  fwd_match #(.ADDR_W(MAX_REG_ADDR_W)) u_match_rt_exmem (
    .src_addr_i  (w_id_rt),
    .src_used_i  (id_use_rt),
    .dst_addr_i  (idex_q.rd),
    .dst_wr_en_i (idex_q.wr_en),
    .match_o     (w_rt_hit_idex)
  );

  fwd_match #(.ADDR_W(MAX_REG_ADDR_W)) u_match_rs_memwb (
    .src_addr_i  (w_id_rs),
    .src_used_i  (id_use_rs),
    .dst_addr_i  (exmem_q.rd),
    .dst_wr_en_i (exmem_q.wr_en),
    .match_o     (w_rs_hit_exmem)
  );

  fwd_match #(.ADDR_W(MAX_REG_ADDR_W)) u_match_rt_memwb (
    .src_addr_i  (w_id_rt),
    .src_used_i  (id_use_rt),
    .dst_addr_i  (exmem_q.rd),
    .dst_wr_en_i (exmem_q.wr_en),
    .match_o     (w_rt_hit_exmem)
  );

  // --------------------------------------------------------------------------
  // Load-use hazard. A load in ID/EX has no data until the end of MEM, so a
  // dependent instruction must wait one cycle and then take the MEM/WB path.
  // The comparator already excludes r0 and non-writing producers. A flush
  // squashes the ID instruction, so there is nothing to stall for.
  // --------------------------------------------------------------------------
  logic w_stall;
  logic w_issue;

  assign w_stall = id_valid & ~ex_flush & idex_q.is_load & (w_rs_hit_idex | w_rt_hit_idex);
  assign w_issue = id_valid & ~w_stall & ~ex_flush;

  // Next ID/EX contents and selects for the instruction entering EX.
  always_comb begin
    idex_d  = SHADOW_BUBBLE;
    sel_a_d = FWD_RF;
    sel_b_d = FWD_RF;
    if (w_issue) begin
      idex_d.rd      = w_id_rd;
      idex_d.wr_en   = id_wr_en;
      idex_d.is_load = id_is_load;
      sel_a_d        = fwd_select(w_rs_hit_idex, w_rs_hit_exmem);
      sel_b_d        = fwd_select(w_rt_hit_idex, w_rt_hit_exmem);
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    cnt_d = cnt_q;
    if (w_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Shadow pipeline, select registers and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= SHADOW_BUBBLE;
      exmem_q <= SHADOW_BUBBLE;
      memwb_q <= SHADOW_BUBBLE;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= idex_q;
      memwb_q <= exmem_q;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // The register file writes before it reads, so the MEM/WB occupant is
  // already visible through the register-file path; it is tracked only to
  // keep the shadow pipeline complete. Likewise a load in EX/MEM needs no
  // special handling. These bits are intentionally unconsumed.
  logic w_unused_ok;
  assign w_unused_ok = ^{memwb_q, exmem_q.is_load};

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ex_sel_a    = sel_a_q;
  assign ex_sel_b    = sel_b_q;
  assign stall       = w_stall;
  assign stall_count = cnt_q;

endmodule : forward_sel_unit
`default_nettype wire

// File: tb/tb_forward_sel_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_sel_unit
// Description : Self-checking bench for forward_sel_unit. Directed hazard
//               scenarios followed by random instruction streams, all checked
//               against a pipeline-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_sel_unit;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_use_rs, id_use_rt, id_wr_en, id_is_load;
  logic          ex_flush;
  logic [1:0]    ex_sel_a, ex_sel_b;
  logic          stall;
  logic [CW-1:0] stall_count;

  forward_sel_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_wr_en    (id_wr_en),
    .id_is_load  (id_is_load),
    .ex_flush    (ex_flush),
    .ex_sel_a    (ex_sel_a),
    .ex_sel_b    (ex_sel_b),
    .stall       (stall),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the last three instructions that entered EX,
  // newest first. A bubble is an entry that writes nothing.
  typedef struct {
    int rd;
    bit wr;
    bit ld;
  } ins_t;

  ins_t pipe [3];
  int   m_sel_a, m_sel_b, m_cnt;
  bit   model_valid = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Which path supplies register addr to an instruction entering EX now.
  function automatic int ref_sel(input int addr, input bit used);
    if (!used || addr == 0) return 0;
    if (pipe[0].wr && pipe[0].rd == addr) return 1;
    if (pipe[1].wr && pipe[1].rd == addr) return 2;
    return 0;
  endfunction

  function automatic bit ref_stall(input bit v, input int rs, input int rt,
                                   input bit urs, input bit urt, input bit fl);
    if (!v || fl) return 0;
    if (!pipe[0].ld || !pipe[0].wr || pipe[0].rd == 0) return 0;
    return (urs && rs == pipe[0].rd) || (urt && rt == pipe[0].rd);
  endfunction

  // One clock cycle: drive the ID instruction, check the combinational stall,
  // advance the model, then check the registered outputs after the edge.
  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input int rd, input bit wr, input bit ld, input bit fl, input bit r);
    bit   exp_stall;
    ins_t entering;
    id_valid   = v;
    id_rs      = AW'(rs);
    id_rt      = AW'(rt);
    id_use_rs  = urs;
    id_use_rt  = urt;
    id_rd      = AW'(rd);
    id_wr_en   = wr;
    id_is_load = ld;
    ex_flush   = fl;
    rst        = r;
    #1;
    exp_stall = ref_stall(v, rs, rt, urs, urt, fl);
    if (model_valid) chk("stall", int'(stall), int'(exp_stall));
    if (r) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{rd: 0, wr: 0, ld: 0};
      m_sel_a = 0;
      m_sel_b = 0;
      m_cnt   = 0;
      model_valid = 1;
    end else begin
      if (exp_stall && m_cnt < (1 << CW) - 1) m_cnt++;
      if (v && !exp_stall && !fl) begin
        m_sel_a  = ref_sel(rs, urs);
        m_sel_b  = ref_sel(rt, urt);
        entering = '{rd: rd, wr: wr, ld: ld};
      end else begin
        m_sel_a  = 0;
        m_sel_b  = 0;
        entering = '{rd: 0, wr: 0, ld: 0};
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = entering;
    end
    @(posedge clk);
    #1;
    chk("sel_a", int'(ex_sel_a), m_sel_a);
    chk("sel_b", int'(ex_sel_b), m_sel_b);
    chk("stall_count", int'(stall_count), m_cnt);
    @(negedge clk);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int saved_cnt;

  initial begin
    // Reset with random ID inputs.
    step($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom), 1'($urandom),
         $urandom_range(0, 31), 1'($urandom), 1'($urandom), 1'($urandom), 1);
    step(1, 5, 5, 1, 1, 5, 1, 1, 0, 1);
    chk("reset_sel_a", int'(ex_sel_a), 0);
    chk("reset_sel_b", int'(ex_sel_b), 0);
    chk("reset_stall_count", int'(stall_count), 0);
    chk("reset_stall", int'(stall), 0);

    // EX/MEM forward: add r3, then sub reading rs=3.
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    step(1, 3, 7, 1, 1, 8, 1, 0, 0, 0);
    chk("exmem_fwd_a", int'(ex_sel_a), 1);
    chk("exmem_fwd_b", int'(ex_sel_b), 0);

    // Two writers of r4 back to back: the newer one wins.
    nop(); nop();
    step(1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 2, 2, 1, 1, 4, 1, 0, 0, 0);
    step(1, 6, 4, 1, 1, 9, 1, 0, 0, 0);
    chk("priority_b", int'(ex_sel_b), 1);

    // Writer, unrelated instruction, reader: MEM/WB path.
    step(1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 2, 2, 1, 1, 10, 1, 0, 0, 0);
    step(1, 6, 4, 1, 1, 11, 1, 0, 0, 0);
    chk("memwb_fwd_b", int'(ex_sel_b), 2);

    // Load-use: lw r5, then add reading rs=5.
    nop(); nop();
    saved_cnt = int'(stall_count);
    step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    step(1, 5, 6, 1, 1, 12, 1, 0, 0, 0);
    chk("loaduse_bubble_sel_a", int'(ex_sel_a), 0);
    step(1, 5, 6, 1, 1, 12, 1, 0, 0, 0);
    chk("loaduse_sel_a", int'(ex_sel_a), 2);
    chk("loaduse_count", int'(stall_count), saved_cnt + 1);

    // Register 0 is never forwarded and never stalls, even for a load.
    nop(); nop();
    step(1, 1, 1, 1, 1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 13, 1, 0, 0, 0);
    chk("r0_sel_a", int'(ex_sel_a), 0);
    step(1, 1, 1, 1, 1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 13, 1, 0, 0, 0);
    chk("r0_alu_sel_a", int'(ex_sel_a), 0);

    // Flush during a load-use condition.
    nop(); nop();
    step(1, 1, 1, 1, 1, 6, 1, 1, 0, 0);
    saved_cnt = int'(stall_count);
    step(1, 6, 6, 1, 1, 14, 1, 0, 1, 0);
    chk("flush_sel_a", int'(ex_sel_a), 0);
    chk("flush_count", int'(stall_count), saved_cnt);

    // Self-dependent load stalls every other cycle; count must saturate.
    nop(); nop();
    for (int i = 0; i < 2 * ((1 << CW) + 3) + 4; i++) step(1, 9, 0, 1, 0, 9, 1, 1, 0, 0);
    chk("saturation", int'(stall_count), (1 << CW) - 1);

    // Reset in mid-stall drops the pending load.
    step(1, 1, 1, 1, 1, 7, 1, 1, 0, 0);
    step(1, 7, 7, 1, 1, 7, 1, 0, 0, 1);
    step(1, 7, 7, 1, 1, 15, 1, 0, 0, 0);
    chk("post_reset_sel_a", int'(ex_sel_a), 0);

    // Random instruction streams with a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 5), $urandom_range(0, 5),
           1'($urandom), 1'($urandom), $urandom_range(0, 5),
           $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 59) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_forward_sel_unit
`default_nettype wire

// File: doc/forward_sel_unit.md
FORWARD_SEL_UNIT -- requirements
Module: forward_sel_unit

Interface
REQ-001 The block SHALL have one parameter, REG_ADDR_W, default 5, giving the register-address width.
REQ-002 The block SHALL have one parameter, CNT_W, default 16, giving the stall-counter width.
REQ-003 clk  input  1  The only clock; every register updates on its rising edge.
REQ-004 rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 id_valid  input  1  The ID-stage instruction is real and not a bubble.
REQ-006 id_rs, id_rt  input  REG_ADDR_W  The ID-stage source register addresses.
REQ-007 id_use_rs, id_use_rt  input  1  The ID-stage instruction reads rs or rt.
REQ-008 id_rd  input  REG_ADDR_W  The ID-stage destination register address.
REQ-009 id_wr_en  input  1  The ID-stage instruction writes id_rd.
REQ-010 id_is_load  input  1  The ID-stage instruction is a load.
REQ-011 ex_flush  input  1  A branch is taken; the instruction entering EX is squashed.
REQ-012 ex_sel_a, ex_sel_b  output  2  Registered select lines for the EX-stage operand A and operand B 3-input muxes.
REQ-013 stall  output  1  Combinational; holds PC and IF/ID and inserts a bubble.
REQ-014 stall_count  output  CNT_W  Saturating count of stall cycles.

Function
REQ-015 Select encoding SHALL be fixed: 2'b00 register-file value, 2'b01 EX/MEM ALU result, 2'b10 MEM/WB writeback data. 2'b11 SHALL never be driven.
REQ-016 The block SHALL keep three shadow stages, ID/EX, EX/MEM and MEM/WB. Each stage holds {rd, wr_en, is_load}.
REQ-017 The shadow stages SHALL advance every cycle: EX/MEM takes ID/EX, and MEM/WB takes EX/MEM.
REQ-018 ID/EX SHALL load the ID fields when id_valid=1, stall=0 and ex_flush=0. Otherwise ID/EX SHALL load a bubble (wr_en=0, is_load=0).
REQ-019 The ex_sel_a and ex_sel_b registers SHALL update on the same edge as ID/EX, for the instruction entering EX.
REQ-020 The select for operand A SHALL be chosen in this priority order:
  - 01 when id_use_rs=1, current ID/EX.wr_en=1, ID/EX.rd==id_rs and id_rs!=0;
  - else 10 when the same test passes against current EX/MEM;
  - else 00.
REQ-021 The select for operand B SHALL use the same rule with rt and id_use_rt.
REQ-022 On a bubble or flush, both select registers SHALL load 00.
REQ-023 Register 0 SHALL never be forwarded.
REQ-024 The newer producer SHALL win when both stages match.
REQ-025 stall SHALL equal id_valid & ~ex_flush & ID/EX.is_load & ID/EX.wr_en & (ID/EX.rd!=0) & ((id_use_rs & rs match) | (id_use_rt & rt match)).
REQ-026 Load-use latency: exactly one stall cycle. The dependent instruction then enters EX with select 10.
REQ-027 A load result SHALL never be selected via 01; REQ-025 guarantees this.
REQ-028 The register file writes before it reads. A match against the stage beyond MEM/WB SHALL yield 00.
REQ-029 stall_count SHALL increment on every cycle with stall=1 and SHALL saturate at all-ones.
REQ-030 ex_flush SHALL take priority over stall and over forwarding in the same cycle.

Reset
REQ-031 While rst=1 at an edge, all shadow stages SHALL clear to rd=0, wr_en=0, is_load=0.
REQ-032 While rst=1 at an edge, ex_sel_a and ex_sel_b SHALL load 00 and stall_count SHALL load 0.
REQ-033 stall SHALL read 0 from the first edge after rst is asserted.
REQ-034 A reset in mid-stall SHALL drop the pending load. No forward SHALL be produced after reset.

Structure
REQ-035 A shared package SHALL hold the select encoding constants FWD_RF=2'b00, FWD_EXMEM=2'b01 and FWD_MEMWB=2'b10.
REQ-036 The same shared package SHALL hold the shadow-stage record type.
REQ-037 The block SHALL contain one sub-module, fwd_match, a combinational comparator instantiated four times (rs/rt × EX/MEM, MEM/WB).
REQ-038 The consuming muxes SHALL sit outside this block.

Verification
REQ-039 Reset: assert rst for 2 cycles with random ID inputs -> sel a/b=00, stall=0, stall_count=0.
REQ-040 EX/MEM forward:
  - stimulus: add r3 (wr_en=1, rd=3), then sub reading rs=3;
  - required: sub's EX cycle has ex_sel_a=01 and ex_sel_b=00.
REQ-041 MEM/WB forward and priority:
  - stimulus: writes to r4 in instr i and i+1, then instr i+2 reads rt=4 → ex_sel_b=01;
  - stimulus: one unrelated instr between the writer and reader → ex_sel_b=10.
REQ-042 Load-use:
  - stimulus: lw r5, then add reading rs=5;
  - required: stall=1 for exactly 1 cycle, ID/EX holds a bubble (sel 00), then add gets ex_sel_a=10 and stall_count=1.
REQ-043 Register 0:
  - stimulus: write to r0, then read rs=0;
  - required: ex_sel_a=00 and stall=0, including when the writer is a load.
REQ-044 Flush:
  - stimulus: ex_flush=1 during a load-use condition;
  - required: stall=0, sel=00, stall_count unchanged.
  - stimulus: hold stall for 2^CNT_W+3 cycles;
  - required: stall_count saturates at all-ones.
